// File: rtl/ifetch_queue.sv
// ifetch_queue: prefetch queue between a req/gnt/rvalid ibus and decode, with redirect flush.
// Define IFQ_BYPASS_EN to present a response to decode in the cycle it arrives when the queue is empty.
module ifetch_queue #(
  parameter int ADDR_W = 16,
  parameter int DEPTH = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_addr,
  output logic                       ibus_req,
  output logic [ADDR_W-1:0]          ibus_addr,
  input  logic                       ibus_gnt,
  input  logic                       ibus_rvalid,
  input  logic [31:0]                ibus_rdata,
  output logic                       out_valid,
  output logic [31:0]                out_instr,
  output logic [ADDR_W-1:0]          out_pc,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);
  logic [31:0]       r_instr [DEPTH];
  logic [ADDR_W-1:0] r_pc [DEPTH];
  logic [PW-1:0]     r_wp, r_rp;
  logic [CW-1:0]     r_count, r_inflight, r_drop;
  logic [ADDR_W-1:0] r_fetch_pc, r_resp_pc;
  logic              w_req, w_fire, w_byp, w_push, w_pop;
  logic [ADDR_W-1:0] w_raddr;
  // Credit rule: queued plus in-flight never exceeds DEPTH, so pushes cannot overflow.
  assign w_req = !rst && !redirect &&
                 ((CW+1)'(r_count) + (CW+1)'(r_inflight) < (CW+1)'(DEPTH)) &&
                 (r_inflight < CW'(MAX_OUTSTANDING));
  assign w_fire = w_req && ibus_gnt;
  assign w_raddr = {redirect_addr[ADDR_W-1:2], 2'b00};
`ifdef IFQ_BYPASS_EN
  assign w_byp = !rst && !redirect && ibus_rvalid && r_count == '0 && r_drop == '0;
`else
  assign w_byp = 1'b0;
`endif
  assign w_push = !rst && !redirect && ibus_rvalid && r_drop == '0 && !(w_byp && out_ready);
  assign w_pop = r_count != '0 && out_ready && !redirect;
  assign ibus_req = w_req;
  assign ibus_addr = r_fetch_pc;
  assign out_valid = !rst && (r_count != '0 || w_byp);
  assign out_instr = w_byp ? ibus_rdata : r_instr[r_rp];
  assign out_pc = w_byp ? r_resp_pc : r_pc[r_rp];
  assign count = rst ? '0 : r_count;
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr[r_wp] <= ibus_rdata;
      r_pc[r_wp] <= r_resp_pc;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc <= RESET_PC;
      r_wp <= '0;
      r_rp <= '0;
      r_count <= '0;
      r_inflight <= '0;
      r_drop <= '0;
    end else begin
      r_inflight <= r_inflight + CW'(w_fire) - CW'(ibus_rvalid);
      if (redirect) begin
        r_wp <= '0;
        r_rp <= '0;
        r_count <= '0;
        r_fetch_pc <= w_raddr;
        r_resp_pc <= w_raddr;
        r_drop <= r_drop + r_inflight - CW'(ibus_rvalid);
      end else begin
        if (w_fire) r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
        if (ibus_rvalid && r_drop != '0) r_drop <= r_drop - CW'(1);
        if (ibus_rvalid && r_drop == '0) r_resp_pc <= r_resp_pc + ADDR_W'(4);
        if (w_push) r_wp <= r_wp + PW'(1);
        if (w_pop) r_rp <= r_rp + PW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) assert (!(w_push && !w_pop && r_count == CW'(DEPTH)));
  end
endmodule
